pipeline_regfile: RTL and testbench

Architectural register file at the receiving end of the writeback stage. Eight 16-bit registers are written from the writeback stage's write/writenum/data triple, and two combinational read ports feed decode. A per-register in-flight-write scoreboard raises a stall for decode when a source register has an uncommitted write pending.

---
 rtl/pipeline_regfile_pkg.sv | 31 +++
 rtl/pipeline_regfile_if.sv | 35 +++
 rtl/regfile_scoreboard.sv | 79 +++++++
 rtl/pipeline_regfile.sv | 58 +++++
 tb/tb_pipeline_regfile.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_regfile_pkg.sv
// Shared types and constants for the writeback-side register file.
// The REGFILE_BYPASS_EN macro selects same-cycle writeback forwarding.
package pipeline_regfile_pkg;

  localparam int unsigned NREG   = 8;
  localparam int unsigned DW     = 16;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned PEND_W = 2;

  typedef logic [IDX_W-1:0] reg_idx_t;
  typedef logic [DW-1:0]    data_t;

  typedef enum logic [3:0] {
    OpNop    = 4'h0,
    OpAlu    = 4'h1,
    OpAluImm = 4'h2,
    OpLoad   = 4'h3,
    OpStore  = 4'h4,
    OpBranch = 4'h5,
    OpJal    = 4'h6
  } opcode_e;

  // Decode drives issue_wr from this classification.
  function automatic logic op_writes_reg(opcode_e op);
    case (op)
      OpAlu, OpAluImm, OpLoad, OpJal: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_regfile_if.sv
// Writeback, issue and read-port bundle between the pipeline and the register file.
interface pipeline_regfile_if #(
  parameter int unsigned DW = 16
);
  import pipeline_regfile_pkg::*;

  logic          write_in;
  reg_idx_t      writenum_in;
  logic [DW-1:0] writeback_data_in;
  logic          issue_valid;
  logic          issue_wr;
  reg_idx_t      issue_dst;
  reg_idx_t      readnum_a;
  reg_idx_t      readnum_b;
  logic          use_a;
  logic          use_b;
  logic [DW-1:0] data_a;
  logic [DW-1:0] data_b;
  logic          stall_out;

  modport master (
    output write_in, writenum_in, writeback_data_in,
    output issue_valid, issue_wr, issue_dst,
    output readnum_a, readnum_b, use_a, use_b,
    input  data_a, data_b, stall_out
  );

  modport slave (
    input  write_in, writenum_in, writeback_data_in,
    input  issue_valid, issue_wr, issue_dst,
    input  readnum_a, readnum_b, use_a, use_b,
    output data_a, data_b, stall_out
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register in-flight write counters and the decode stall they produce.
// With REGFILE_BYPASS_EN a single pending write that commits this cycle is not a hazard.
module regfile_scoreboard
  import pipeline_regfile_pkg::*;
#(
  parameter int unsigned NREG   = pipeline_regfile_pkg::NREG,
  parameter int unsigned PEND_W = pipeline_regfile_pkg::PEND_W
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     write_in,
  input  reg_idx_t writenum_in,
  input  logic     issue_valid,
  input  logic     issue_wr,
  input  reg_idx_t issue_dst,
  input  reg_idx_t readnum_a,
  input  reg_idx_t readnum_b,
  input  logic     use_a,
  input  logic     use_b,
  output logic     stall_out
);

  localparam logic [PEND_W-1:0] PendMax = '1;

  logic [PEND_W-1:0] pend_q [NREG];
  logic [PEND_W-1:0] pend_d [NREG];
  logic [NREG-1:0]   inc;
  logic [NREG-1:0]   dec;
  logic [NREG-1:0]   haz;
  logic              sat;
  logic              accept;

  always_comb begin
    dec = '0;
    haz = '0;
    for (int r = 0; r < NREG; r++) begin
      dec[r] = write_in && (writenum_in == reg_idx_t'(r));
      haz[r] = (pend_q[r] != '0);
`ifdef REGFILE_BYPASS_EN
      if (pend_q[r] == PEND_W'(1) && dec[r]) haz[r] = 1'b0;
`endif
    end
  end

  // A commit to the destination in the same cycle frees a slot, so the counter cannot wrap.
  always_comb begin
    sat       = issue_wr && (pend_q[issue_dst] == PendMax) && !dec[issue_dst];
    stall_out = issue_valid && ((use_a && haz[readnum_a]) || (use_b && haz[readnum_b]) || sat);
    accept    = issue_valid && !stall_out;
  end

  always_comb begin
    inc = '0;
    for (int r = 0; r < NREG; r++) begin
      inc[r]    = accept && issue_wr && (issue_dst == reg_idx_t'(r));
      pend_d[r] = pend_q[r];
      if (inc[r] && !dec[r]) begin
        pend_d[r] = pend_q[r] + PEND_W'(1);
      end else if (dec[r] && !inc[r] && pend_q[r] != '0) begin
        pend_d[r] = pend_q[r] - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) pend_q[r] <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

`ifndef SYNTHESIS
  dec_underflow_a: assert property (@(posedge clk) disable iff (!rst)
    !(write_in && pend_q[writenum_in] == '0))
    else $error("regfile_scoreboard: commit to r%0d with no pending write", writenum_in);
`endif

endmodule

// File: rtl/pipeline_regfile.sv
// Eight-entry architectural register file with writeback port, two read ports and a
// hazard scoreboard. Define REGFILE_BYPASS_EN to forward writeback data to the read ports.
module pipeline_regfile
  import pipeline_regfile_pkg::*;
#(
  parameter int unsigned NREG   = pipeline_regfile_pkg::NREG,
  parameter int unsigned DW     = pipeline_regfile_pkg::DW,
  parameter int unsigned PEND_W = pipeline_regfile_pkg::PEND_W
) (
  input logic               clk,
  input logic               rst,
  pipeline_regfile_if.slave rf
);

  logic [DW-1:0] regs_q [NREG];
  logic [DW-1:0] regs_d [NREG];

  always_comb begin
    regs_d = regs_q;
    if (rf.write_in) regs_d[rf.writenum_in] = rf.writeback_data_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++) regs_q[r] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    rf.data_a = regs_q[rf.readnum_a];
    rf.data_b = regs_q[rf.readnum_b];
`ifdef REGFILE_BYPASS_EN
    if (rf.write_in && rf.writenum_in == rf.readnum_a) rf.data_a = rf.writeback_data_in;
    if (rf.write_in && rf.writenum_in == rf.readnum_b) rf.data_b = rf.writeback_data_in;
`endif
  end

  regfile_scoreboard #(
    .NREG   (NREG),
    .PEND_W (PEND_W)
  ) u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .write_in    (rf.write_in),
    .writenum_in (rf.writenum_in),
    .issue_valid (rf.issue_valid),
    .issue_wr    (rf.issue_wr),
    .issue_dst   (rf.issue_dst),
    .readnum_a   (rf.readnum_a),
    .readnum_b   (rf.readnum_b),
    .use_a       (rf.use_a),
    .use_b       (rf.use_b),
    .stall_out   (rf.stall_out)
  );

endmodule

// File: tb/tb_pipeline_regfile.sv
// Directed bench for pipeline_regfile: stimulus queues expected outputs, a monitor compares.
module tb_pipeline_regfile;
  import pipeline_regfile_pkg::*;

`ifdef REGFILE_BYPASS_EN
  localparam bit Byp = 1'b1;
`else
  localparam bit Byp = 1'b0;
`endif

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic kick = 1'b0;

  always #5 clk = ~clk;

  pipeline_regfile_if #(.DW(16)) rf ();

  pipeline_regfile #(
    .NREG   (8),
    .DW     (16),
    .PEND_W (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rf  (rf)
  );

  typedef struct {
    string       name;
    bit          ca;
    logic [15:0] a;
    bit          cb;
    logic [15:0] b;
    logic        st;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: compares every queued expectation at the negedge (or on an explicit kick).
  always @(negedge clk or posedge kick) begin
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_tests++;
      if (rf.stall_out !== e.st) begin
        n_fail++;
        $display("FAIL %s stall_out: got %b want %b", e.name, rf.stall_out, e.st);
      end
      if (e.ca) begin
        n_tests++;
        if (rf.data_a !== e.a) begin
          n_fail++;
          $display("FAIL %s data_a: got %h want %h", e.name, rf.data_a, e.a);
        end
      end
      if (e.cb) begin
        n_tests++;
        if (rf.data_b !== e.b) begin
          n_fail++;
          $display("FAIL %s data_b: got %h want %h", e.name, rf.data_b, e.b);
        end
      end
    end
  end

  task automatic idle();
    rf.write_in          = 1'b0;
    rf.writenum_in       = '0;
    rf.writeback_data_in = '0;
    rf.issue_valid       = 1'b0;
    rf.issue_wr          = 1'b0;
    rf.issue_dst         = '0;
    rf.readnum_a         = '0;
    rf.readnum_b         = '0;
    rf.use_a             = 1'b0;
    rf.use_b             = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(string nm, bit ca, logic [15:0] a, bit cb, logic [15:0] b,
                            logic st);
    exp_t e;
    e.name = nm;
    e.ca   = ca;
    e.a    = a;
    e.cb   = cb;
    e.b    = b;
    e.st   = st;
    exp_q.push_back(e);
  endtask

  task automatic issue_wr_to(reg_idx_t dst);
    rf.issue_valid = 1'b1;
    rf.issue_wr    = 1'b1;
    rf.issue_dst   = dst;
  endtask

  task automatic commit(reg_idx_t r, logic [15:0] d);
    rf.write_in          = 1'b1;
    rf.writenum_in       = r;
    rf.writeback_data_in = d;
  endtask

  initial begin
    idle();
    expect_out("reset_out", 1'b1, 16'h0, 1'b1, 16'h0, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b1;
    step();

    for (int r = 0; r < 8; r++) begin
      rf.readnum_a = reg_idx_t'(r);
      rf.readnum_b = reg_idx_t'(7 - r);
      expect_out($sformatf("read_zero_%0d", r), 1'b1, 16'h0, 1'b1, 16'h0, 1'b0);
      step();
    end

    idle(); issue_wr_to(3);
    expect_out("issue_r3", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    step();
    idle(); commit(3, 16'h1234); rf.readnum_a = 3; rf.readnum_b = 4;
    expect_out("commit_r3", 1'b1, Byp ? 16'h1234 : 16'h0, 1'b1, 16'h0, 1'b0);
    step();
    idle(); rf.readnum_a = 3; rf.readnum_b = 4;
    expect_out("read_r3", 1'b1, 16'h1234, 1'b1, 16'h0, 1'b0);
    step();

    idle(); issue_wr_to(5);
    expect_out("issue_r5", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    step();
    idle(); rf.issue_valid = 1'b1; rf.readnum_b = 5; rf.use_b = 1'b1;
    expect_out("raw_r5", 1'b0, 16'h0, 1'b1, 16'h0, 1'b1);
    step();
    commit(5, 16'hBEEF);
    expect_out("commit_r5", 1'b0, 16'h0, 1'b1, Byp ? 16'hBEEF : 16'h0, Byp ? 1'b0 : 1'b1);
    step();
    rf.write_in = 1'b0;
    expect_out("after_r5", 1'b0, 16'h0, 1'b1, 16'hBEEF, 1'b0);
    step();

    idle(); issue_wr_to(2);
    for (int i = 0; i < 3; i++) begin
      expect_out($sformatf("issue_r2_%0d", i), 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
      step();
    end
    expect_out("sat_r2", 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    step();
    commit(2, 16'h2222);
    expect_out("sat_relief", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    step();
    rf.write_in = 1'b0;
    expect_out("sat_hold", 1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    step();

    idle(); commit(2, 16'h2223); issue_wr_to(1);
    expect_out("issue_r1", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    step();
    idle(); commit(1, 16'h00FF);
    expect_out("commit_r1", 1'b0, 16'h0, 1'b0, 16'h0, 1'b0);
    step();
    idle(); rf.issue_valid = 1'b1; rf.readnum_a = 2; rf.use_a = 1'b1; rf.readnum_b = 1;
    expect_out("pre_reset", 1'b1, 16'h2223, 1'b1, 16'h00FF, 1'b1);

    // Reset lands between clock edges; outputs must clear before the next edge.
    @(negedge clk);
    #1;
    rst = 1'b0;
    rf.issue_wr  = 1'b1;
    rf.issue_dst = 2;
    #1;
    expect_out("async_reset", 1'b1, 16'h0, 1'b1, 16'h0, 1'b0);
    kick = 1'b1;
    #1;
    kick = 1'b0;
    step();
    rst = 1'b1;
    expect_out("post_reset", 1'b1, 16'h0, 1'b1, 16'h0, 1'b0);
    step();

    idle();
    @(negedge clk);
    #1;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
